// File: rtl/key_event_pkg.sv
// Shared definitions for the key event controller: event codes, per-key
// state encoding and the millisecond-to-tick conversion.
package key_event_pkg;

  localparam logic [2:0] EVT_NONE   = 3'd0;
  localparam logic [2:0] EVT_SHORT  = 3'd1;
  localparam logic [2:0] EVT_DOUBLE = 3'd2;
  localparam logic [2:0] EVT_LONG   = 3'd3;
  localparam logic [2:0] EVT_REPEAT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESS1  = 3'd1,
    ST_WAIT2   = 3'd2,
    ST_PRESS2  = 3'd3,
    ST_HOLD    = 3'd4,
    ST_WAITREL = 3'd5
  } key_state_e;

  // Number of clock cycles in ms milliseconds at freq_mhz MHz.
  function automatic longint unsigned ms_to_ticks(input longint unsigned ms,
                                                  input longint unsigned freq_mhz);
    return ms * 64'd1000 * freq_mhz;
  endfunction

endpackage

// File: rtl/key_event_fsm.sv
// One key's gesture classifier: press/release sequencing, hold timer and a
// single-entry pending slot that the arbiter drains.
module key_event_fsm
  import key_event_pkg::*;
#(
  parameter int unsigned     TW           = 32,
  parameter logic [TW-1:0]   LONG_LAST    = '0,
  parameter logic [TW-1:0]   DCLICK_LAST  = '0,
  parameter logic [TW-1:0]   REPEAT_LAST  = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_press,
  input  logic       key_release,
  input  logic       grant,
  output logic       pend_valid,
  output logic [2:0] pend_type,
  output logic       ovf_set
);

  key_state_e    state_r;
  key_state_e    next_state_s;
  logic [TW-1:0] timer_r;
  logic          press_s;
  logic          rel_s;
  logic          emit_s;
  logic [2:0]    emit_type_s;
  logic          timer_clr_s;
  logic          pend_valid_r;
  logic [2:0]    pend_type_r;

  // A press and release in the same cycle cancel each other.
  assign press_s = key_press & ~key_release;
  assign rel_s   = key_release & ~key_press;

  // Timer restarts on every state change and after each REPEAT.
  assign timer_clr_s = (next_state_s != state_r) | ((state_r == ST_HOLD) & emit_s);

  // Slot is full and nobody drains it this cycle: the new event is lost.
  assign ovf_set    = emit_s & pend_valid_r & ~grant;
  assign pend_valid = pend_valid_r;
  assign pend_type  = pend_type_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode from key edges and timer expiry; edges win over expiry.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (press_s) next_state_s = ST_PRESS1;
        else         next_state_s = ST_IDLE;
      end
      ST_PRESS1: begin
        if (rel_s)                       next_state_s = ST_WAIT2;
        else if (timer_r == LONG_LAST)   next_state_s = ST_HOLD;
        else                             next_state_s = ST_PRESS1;
      end
      ST_WAIT2: begin
        if (press_s)                     next_state_s = ST_PRESS2;
        else if (timer_r == DCLICK_LAST) next_state_s = ST_IDLE;
        else                             next_state_s = ST_WAIT2;
      end
      ST_PRESS2: begin
        if (rel_s)                       next_state_s = ST_IDLE;
        else if (timer_r == LONG_LAST)   next_state_s = ST_WAITREL;
        else                             next_state_s = ST_PRESS2;
      end
      ST_HOLD: begin
        if (rel_s) next_state_s = ST_IDLE;
        else       next_state_s = ST_HOLD;
      end
      ST_WAITREL: begin
        if (rel_s) next_state_s = ST_IDLE;
        else       next_state_s = ST_WAITREL;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Event emission; SHORT waits for the double-click window to close.
  always_comb begin
    emit_s      = 1'b0;
    emit_type_s = EVT_NONE;
    case (state_r)
      ST_PRESS1: begin
        if (!rel_s && (timer_r == LONG_LAST)) begin
          emit_s      = 1'b1;
          emit_type_s = EVT_LONG;
        end else begin
          emit_s      = 1'b0;
          emit_type_s = EVT_NONE;
        end
      end
      ST_WAIT2: begin
        if (!press_s && (timer_r == DCLICK_LAST)) begin
          emit_s      = 1'b1;
          emit_type_s = EVT_SHORT;
        end else begin
          emit_s      = 1'b0;
          emit_type_s = EVT_NONE;
        end
      end
      ST_PRESS2: begin
        if (rel_s || (timer_r == LONG_LAST)) begin
          emit_s      = 1'b1;
          emit_type_s = EVT_DOUBLE;
        end else begin
          emit_s      = 1'b0;
          emit_type_s = EVT_NONE;
        end
      end
      ST_HOLD: begin
        if (!rel_s && (timer_r == REPEAT_LAST)) begin
          emit_s      = 1'b1;
          emit_type_s = EVT_REPEAT;
        end else begin
          emit_s      = 1'b0;
          emit_type_s = EVT_NONE;
        end
      end
      default: begin
        emit_s      = 1'b0;
        emit_type_s = EVT_NONE;
      end
    endcase
  end

  // Saturating per-key timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= '0;
    end else if (timer_clr_s) begin
      timer_r <= '0;
    end else if (timer_r != {TW{1'b1}}) begin
      timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  // Pending slot: a grant frees it, and it may be refilled in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_r <= 1'b0;
      pend_type_r  <= EVT_NONE;
    end else if (emit_s && !(pend_valid_r && !grant)) begin
      pend_valid_r <= 1'b1;
      pend_type_r  <= emit_type_s;
    end else if (grant) begin
      pend_valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Classifies debounced key edges into SHORT/DOUBLE/LONG/REPEAT events and
// round-robin serialises them onto one valid/ready event port.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int unsigned NUM_KEYS  = 4,
  parameter int unsigned FREQ      = 100,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned REPEAT_MS = 200,
  parameter int unsigned TW        = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_press,
  input  logic [NUM_KEYS-1:0] key_release,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [3:0]          evt_key,
  output logic [2:0]          evt_type,
  input  logic                ovf_clr,
  output logic                evt_ovf
);

  // Timers compare against the last cycle of each interval.
  localparam logic [TW-1:0] LONG_LAST   = TW'(ms_to_ticks(64'(LONG_MS),   64'(FREQ)) - 64'd1);
  localparam logic [TW-1:0] DCLICK_LAST = TW'(ms_to_ticks(64'(DCLICK_MS), 64'(FREQ)) - 64'd1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(ms_to_ticks(64'(REPEAT_MS), 64'(FREQ)) - 64'd1);

  logic [NUM_KEYS-1:0]   pend_valid_s;
  logic [2:0]            pend_type_s [NUM_KEYS];
  logic [NUM_KEYS-1:0]   grant_s;
  logic [NUM_KEYS-1:0]   ovf_set_s;
  logic [2*NUM_KEYS-1:0] pend_dbl_s;
  logic [2*NUM_KEYS-1:0] pend_rot_s;
  logic                  grant_any_s;
  logic [3:0]            grant_idx_s;
  logic [2:0]            grant_type_s;
  logic [4:0]            scan_sum_s;
  logic [4:0]            ptr_inc_s;
  logic [3:0]            ptr_next_s;
  logic                  load_s;

  logic                  evt_valid_r;
  logic [3:0]            evt_key_r;
  logic [2:0]            evt_type_r;
  logic                  evt_ovf_r;
  logic [3:0]            rr_ptr_r;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_event_fsm #(
      .TW          (TW),
      .LONG_LAST   (LONG_LAST),
      .DCLICK_LAST (DCLICK_LAST),
      .REPEAT_LAST (REPEAT_LAST)
    ) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_press   (key_press[k]),
      .key_release (key_release[k]),
      .grant       (grant_s[k]),
      .pend_valid  (pend_valid_s[k]),
      .pend_type   (pend_type_s[k]),
      .ovf_set     (ovf_set_s[k])
    );
  end

  assign evt_valid = evt_valid_r;
  assign evt_key   = evt_key_r;
  assign evt_type  = evt_type_r;
  assign evt_ovf   = evt_ovf_r;

  // Round-robin search: rotate the pending mask so the pointer lands on bit 0.
  always_comb begin
    pend_dbl_s  = {pend_valid_s, pend_valid_s};
    pend_rot_s  = pend_dbl_s >> rr_ptr_r;
    grant_any_s = 1'b0;
    grant_idx_s = 4'd0;
    scan_sum_s  = 5'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!grant_any_s && pend_rot_s[i]) begin
        grant_any_s = 1'b1;
        scan_sum_s  = {1'b0, rr_ptr_r} + 5'(i);
        if (scan_sum_s >= 5'(NUM_KEYS)) scan_sum_s = scan_sum_s - 5'(NUM_KEYS);
        else                            scan_sum_s = scan_sum_s;
        grant_idx_s = scan_sum_s[3:0];
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // Grant only when the output register can take a new event this cycle.
  always_comb begin
    load_s       = ~evt_valid_r | evt_ready;
    grant_s      = '0;
    grant_type_s = EVT_NONE;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (load_s && grant_any_s && (grant_idx_s == 4'(k))) begin
        grant_s[k]   = 1'b1;
        grant_type_s = pend_type_s[k];
      end else begin
        grant_s[k]   = 1'b0;
      end
    end
    ptr_inc_s = {1'b0, grant_idx_s} + 5'd1;
    if (ptr_inc_s >= 5'(NUM_KEYS)) ptr_next_s = 4'd0;
    else                           ptr_next_s = ptr_inc_s[3:0];
  end

  // Output register and RR pointer; reloads directly on acceptance (no bubble).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_r <= 1'b0;
      evt_key_r   <= 4'd0;
      evt_type_r  <= EVT_NONE;
      rr_ptr_r    <= 4'd0;
    end else if (load_s) begin
      if (grant_any_s) begin
        evt_valid_r <= 1'b1;
        evt_key_r   <= grant_idx_s;
        evt_type_r  <= grant_type_s;
        rr_ptr_r    <= ptr_next_s;
      end else begin
        evt_valid_r <= 1'b0;
      end
    end
  end

  // Sticky overflow flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_ovf_r <= 1'b0;
    end else if (|ovf_set_s) begin
      evt_ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      evt_ovf_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a gesture-level reference model
// checked against the DUT every cycle, plus hand-computed event timings.
module tb_key_event_ctrl;

  localparam int NK     = 4;
  localparam int LONG_T = 2 * 1000 * 1;
  localparam int DCL_T  = 1 * 1000 * 1;
  localparam int REP_T  = 1 * 1000 * 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic          evt_valid;
  logic          evt_ready;
  logic [3:0]    evt_key;
  logic [2:0]    evt_type;
  logic          ovf_clr;
  logic          evt_ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // gesture model state
  int         g_clicks [NK];
  bit         g_held   [NK];
  bit         g_longed [NK];
  bit         g_quiet  [NK];
  int         g_mark   [NK];
  bit         m_pend   [NK];
  logic [2:0] m_ptype  [NK];
  logic       m_valid;
  logic [3:0] m_key;
  logic [2:0] m_type;
  int         m_ptr;
  logic       m_ovf;

  // accepted-event log taken from the DUT
  int lg_cyc[$];
  int lg_key[$];
  int lg_type[$];

  key_event_ctrl #(
    .NUM_KEYS(NK), .FREQ(1), .LONG_MS(2), .DCLICK_MS(1), .REPEAT_MS(1), .TW(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_press(key_press), .key_release(key_release),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_type(evt_type), .ovf_clr(ovf_clr), .evt_ovf(evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      g_clicks[k] = 0; g_held[k] = 0; g_longed[k] = 0; g_quiet[k] = 0; g_mark[k] = 0;
      m_pend[k] = 0; m_ptype[k] = 3'd0;
    end
    m_valid = 1'b0; m_key = 4'd0; m_type = 3'd0; m_ptr = 0; m_ovf = 1'b0;
  endtask

  task automatic clear_gesture(input int k);
    g_clicks[k] = 0; g_held[k] = 0; g_longed[k] = 0; g_quiet[k] = 0;
  endtask

  task automatic model_step();
    bit drop_any;
    drop_any = 0;
    // output register / round robin
    if (!m_valid || evt_ready) begin
      int g;
      g = -1;
      for (int i = 0; i < NK; i++)
        if (g < 0 && m_pend[(m_ptr + i) % NK]) g = (m_ptr + i) % NK;
      if (g >= 0) begin
        m_valid = 1'b1; m_key = 4'(g); m_type = m_ptype[g];
        m_pend[g] = 0; m_ptr = (g + 1) % NK;
      end else begin
        m_valid = 1'b0;
      end
    end
    // gestures
    for (int k = 0; k < NK; k++) begin
      bit p, r, em;
      int el;
      logic [2:0] et;
      p  = key_press[k] & ~key_release[k];
      r  = key_release[k] & ~key_press[k];
      el = cyc - g_mark[k];
      em = 0; et = 3'd0;
      if (g_clicks[k] == 0) begin
        if (p) begin g_clicks[k] = 1; g_held[k] = 1; g_mark[k] = cyc; end
      end else if (g_quiet[k]) begin
        if (r) clear_gesture(k);
      end else if (g_longed[k]) begin
        if (r) clear_gesture(k);
        else if (el == REP_T) begin em = 1; et = 3'd4; g_mark[k] = cyc; end
      end else if (g_clicks[k] == 1 && g_held[k]) begin
        if (r) begin g_held[k] = 0; g_mark[k] = cyc; end
        else if (el == LONG_T) begin em = 1; et = 3'd3; g_longed[k] = 1; g_mark[k] = cyc; end
      end else if (g_clicks[k] == 1) begin
        if (p) begin g_clicks[k] = 2; g_held[k] = 1; g_mark[k] = cyc; end
        else if (el == DCL_T) begin em = 1; et = 3'd1; clear_gesture(k); end
      end else begin
        if (r) begin em = 1; et = 3'd2; clear_gesture(k); end
        else if (el == LONG_T) begin em = 1; et = 3'd2; g_quiet[k] = 1; end
      end
      if (em) begin
        if (m_pend[k]) drop_any = 1;
        else begin m_pend[k] = 1; m_ptype[k] = et; end
      end
    end
    if (drop_any) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  // reference model, advanced on the same edges as the DUT
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        cyc++;
        model_step();
      end
    end
  end

  // per-cycle compare and acceptance log
  initial begin
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      check("cmp_valid", evt_valid, m_valid);
      check("cmp_key",   evt_key,   m_key);
      check("cmp_type",  evt_type,  m_type);
      check("cmp_ovf",   evt_ovf,   m_ovf);
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
        lg_cyc.push_back(cyc);
        lg_key.push_back(int'(evt_key));
        lg_type.push_back(int'(evt_type));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input logic [NK-1:0] pm, input logic [NK-1:0] rm, output int edge_n);
    key_press = pm; key_release = rm;
    @(posedge clk); #1;
    edge_n = cyc;
    key_press = '0; key_release = '0;
  endtask

  task automatic clear_log();
    lg_cyc.delete(); lg_key.delete(); lg_type.delete();
  endtask

  initial begin
    int p, r, r2, dummy;
    rst_n = 1'b0; key_press = '0; key_release = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
    step(3);
    check("rst_valid", evt_valid, 0);
    check("rst_key",   evt_key,   0);
    check("rst_type",  evt_type,  0);
    check("rst_ovf",   evt_ovf,   0);
    rst_n = 1'b1;
    step(2);

    // 1: single click -> SHORT after the double-click window
    clear_log();
    pulse(4'b0001, 4'b0000, p);
    step(99);
    pulse(4'b0000, 4'b0001, r);
    check("t1_gap", r - p, 100);
    step(1100);
    check("t1_count", lg_key.size(), 1);
    if (lg_key.size() > 0) begin
      check("t1_lat",  lg_cyc[0] - r, 1001);
      check("t1_key",  lg_key[0], 0);
      check("t1_type", lg_type[0], 1);
    end

    // 2: double click
    clear_log();
    pulse(4'b0010, 4'b0000, p);
    step(9);
    pulse(4'b0000, 4'b0010, r);
    step(499);
    pulse(4'b0010, 4'b0000, dummy);
    step(49);
    pulse(4'b0000, 4'b0010, r2);
    step(1200);
    check("t2_count", lg_key.size(), 1);
    if (lg_key.size() > 0) begin
      check("t2_lat",  lg_cyc[0] - r2, 1);
      check("t2_key",  lg_key[0], 1);
      check("t2_type", lg_type[0], 2);
    end

    // 3: hold 4500 cycles -> LONG, REPEAT, REPEAT
    clear_log();
    pulse(4'b0100, 4'b0000, p);
    step(4499);
    pulse(4'b0000, 4'b0100, r);
    step(1500);
    check("t3_count", lg_key.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < lg_key.size()) begin
        check($sformatf("t3_lat%0d", i),  lg_cyc[i] - p, 2001 + 1000 * i);
        check($sformatf("t3_key%0d", i),  lg_key[i], 2);
        check($sformatf("t3_type%0d", i), lg_type[i], (i == 0) ? 3 : 4);
      end
    end

    // 4: simultaneous SHORTs, pointer 0 then pointer 2
    rst_n = 1'b0; step(2); rst_n = 1'b1; step(2);
    clear_log();
    pulse(4'b1111, 4'b0000, p);
    step(9);
    pulse(4'b0000, 4'b1111, r);
    step(1010);
    check("t4a_count", lg_key.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < lg_key.size()) begin
        check($sformatf("t4a_key%0d", i), lg_key[i], i);
        check($sformatf("t4a_lat%0d", i), lg_cyc[i] - r, 1001 + i);
      end
    end
    clear_log();
    pulse(4'b0010, 4'b0000, p);
    step(9);
    pulse(4'b0000, 4'b0010, r);
    step(1010);
    check("t4_ptr_evt", lg_key.size(), 1);
    clear_log();
    pulse(4'b1111, 4'b0000, p);
    step(9);
    pulse(4'b0000, 4'b1111, r);
    step(1010);
    check("t4b_count", lg_key.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < lg_key.size()) begin
        check($sformatf("t4b_key%0d", i), lg_key[i], (i + 2) % 4);
        check($sformatf("t4b_lat%0d", i), lg_cyc[i] - r, 1001 + i);
      end
    end

    // 5: stalled consumer, overflow and clear
    evt_ready = 1'b0;
    clear_log();
    pulse(4'b0001, 4'b0000, p);
    step(9);
    pulse(4'b0000, 4'b0001, r);
    step(1010);
    pulse(4'b0001, 4'b0000, p);
    step(3009);
    check("t5_valid", evt_valid, 1);
    check("t5_key",   evt_key,   0);
    check("t5_type",  evt_type,  1);
    check("t5_ovf",   evt_ovf,   1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("t5_ovf_clr", evt_ovf, 0);
    pulse(4'b0000, 4'b0001, r);
    evt_ready = 1'b1;
    step(5);
    check("t5_count", lg_key.size(), 2);
    if (lg_key.size() > 1) begin
      check("t5_first",  lg_type[0], 1);
      check("t5_second", lg_type[1], 3);
    end
    check("t5_ovf_end", evt_ovf, 0);

    // 6: reset while holding
    evt_ready = 1'b0;
    clear_log();
    pulse(4'b1000, 4'b0000, p);
    step(2100);
    check("t6_pre_valid", evt_valid, 1);
    check("t6_pre_key",   evt_key,   3);
    check("t6_pre_type",  evt_type,  3);
    rst_n = 1'b0;
    #2;
    check("t6_rst_valid", evt_valid, 0);
    check("t6_rst_key",   evt_key,   0);
    check("t6_rst_type",  evt_type,  0);
    check("t6_rst_ovf",   evt_ovf,   0);
    step(1);
    step(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    step(2);
    clear_log();
    pulse(4'b0000, 4'b1000, r);
    step(1500);
    check("t6_no_evt", lg_key.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
